ifconv_round: RTL and testbench

- Rounding and packing stage that consumes the normalized integer-to-float datapath result: sign, 16-bit biased exponent (bias 16'h7fff) and 64-bit left-justified mantissa.
- Rounds the mantissa to single, double or extended precision under a selectable rounding mode.
- Repacks the result into the 82-bit FP register-file format with a type tag, through a 2-stage clkEn-gated pipeline.
- Output valid is carried on alt.

---
 rtl/ifconv_round.sv | 182 ++++++++++++++++++
 tb/tb_ifconv_round.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifconv_round.sv
// Rounding and packing stage for the integer-to-float path: rounds a left-justified
// 64-bit mantissa to SNG/DBL/EXT precision and packs it into the 82-bit FP register format.
`ifndef PTYPE_SNGL
`define PTYPE_SNGL 2'b01
`endif
`ifndef PTYPE_DBL
`define PTYPE_DBL 2'b10
`endif
`ifndef PTYPE_EXT
`define PTYPE_EXT 2'b11
`endif

module ifconv_round #(
    parameter logic [15:0] BIAS = 16'h7fff
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clkEn,
    input  logic        sgn,
    input  logic [15:0] expn,
    input  logic [63:0] mant,
    input  logic        zro,
    input  logic        toDBL,
    input  logic        toEXT,
    input  logic        toSNG,
    input  logic [2:0]  rmode,
    output logic [81:0] res,
    output logic [1:0]  rtyp,
    output logic        alt,
    output logic        inexact
);

    typedef enum logic [1:0] {
        FMT_NONE = 2'b00,
        FMT_SNG  = `PTYPE_SNGL,
        FMT_DBL  = `PTYPE_DBL,
        FMT_EXT  = `PTYPE_EXT
    } fmt_e;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rmode_e;

    // Weight of the last kept mantissa bit for each target precision.
    function automatic logic [63:0] ulp_of(input fmt_e f);
        case (f)
            FMT_SNG: ulp_of = 64'h0000_0100_0000_0000;
            FMT_DBL: ulp_of = 64'h0000_0000_0000_0800;
            default: ulp_of = 64'h0000_0000_0000_0001;
        endcase
    endfunction

    // ---------------- stage 1: split and round decision ----------------
    fmt_e        fmt;
    logic [63:0] keep_lj;
    logic        guard;
    logic        sticky;
    logic        lsb;
    logic        inc;

    always_comb begin
        fmt = FMT_NONE;
        if (toSNG)
            fmt = FMT_SNG;
        else if (toDBL)
            fmt = FMT_DBL;
        else if (toEXT)
            fmt = FMT_EXT;
    end

    // Keep bits stay left-justified so stage 2 rounds every format with one 65-bit add.
    always_comb begin
        keep_lj = mant;
        guard   = 1'b0;
        sticky  = 1'b0;
        case (fmt)
            FMT_SNG: begin
                keep_lj = {mant[63:40], 40'b0};
                guard   = mant[39];
                sticky  = |mant[38:0];
            end
            FMT_DBL: begin
                keep_lj = {mant[63:11], 11'b0};
                guard   = mant[10];
                sticky  = |mant[9:0];
            end
            default: ;
        endcase
    end

    assign lsb = |(keep_lj & ulp_of(fmt));

    always_comb begin
        inc = 1'b0;
        case (rmode_e'(rmode))
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sgn & (guard | sticky);
            RM_RUP:  inc = ~sgn & (guard | sticky);
            RM_RMM:  inc = guard;
            default: inc = guard & (sticky | lsb);
        endcase
    end

    logic        s1_valid;
    logic        s1_sgn;
    logic [15:0] s1_expn;
    logic [63:0] s1_keep;
    logic        s1_inc;
    logic        s1_inexact;
    fmt_e        s1_fmt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid   <= 1'b0;
            s1_sgn     <= 1'b0;
            s1_expn    <= '0;
            s1_keep    <= '0;
            s1_inc     <= 1'b0;
            s1_inexact <= 1'b0;
            s1_fmt     <= FMT_NONE;
        end else if (clkEn) begin
            s1_valid <= en;
            s1_sgn   <= sgn;
            s1_fmt   <= fmt;
            if (zro) begin
                s1_expn    <= '0;
                s1_keep    <= '0;
                s1_inc     <= 1'b0;
                s1_inexact <= 1'b0;
            end else begin
                s1_expn    <= expn;
                s1_keep    <= keep_lj;
                s1_inc     <= inc;
                s1_inexact <= guard | sticky;
            end
        end
    end

    // ---------------- stage 2: increment, renormalise, pack ----------------
    logic [64:0] sum;
    logic        carry;
    logic [63:0] m;
    logic [15:0] e;
    logic [81:0] packed_res;

    always_comb begin
        sum   = {1'b0, s1_keep} + (s1_inc ? {1'b0, ulp_of(s1_fmt)} : 65'd0);
        carry = sum[64];
        m     = carry ? {1'b1, 63'b0} : sum[63:0];
        e     = s1_expn + {15'b0, carry};
    end

    always_comb begin
        packed_res = '0;
        case (s1_fmt)
            FMT_SNG: packed_res = {49'b0, e[6], s1_sgn, e[15], e[6:0], m[62:40]};
            FMT_DBL: packed_res = {17'b0, e[9], s1_sgn, e[15], e[8:0], m[62:43], 1'b0, m[42:11]};
            FMT_EXT: packed_res = {e[15], s1_sgn, e[13:0], e[14], m[63:32], 1'b0, m[31:0]};
            default: packed_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res     <= '0;
            rtyp    <= '0;
            alt     <= 1'b0;
            inexact <= 1'b0;
        end else if (clkEn) begin
            res     <= packed_res;
            rtyp    <= s1_fmt;
            alt     <= s1_valid;
            inexact <= s1_inexact;
        end
    end

endmodule

// File: tb/tb_ifconv_round.sv
// Scoreboard bench for ifconv_round: directed corner cases plus randomized traffic
// compared against an arithmetic rounding model.
`ifndef PTYPE_SNGL
`define PTYPE_SNGL 2'b01
`endif
`ifndef PTYPE_DBL
`define PTYPE_DBL 2'b10
`endif
`ifndef PTYPE_EXT
`define PTYPE_EXT 2'b11
`endif

module tb_ifconv_round;

    localparam logic [1:0] SNGL = `PTYPE_SNGL;
    localparam logic [1:0] DBL  = `PTYPE_DBL;
    localparam logic [1:0] EXT  = `PTYPE_EXT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        clkEn = 1'b0;
    logic        sgn = 1'b0;
    logic [15:0] expn = '0;
    logic [63:0] mant = '0;
    logic        zro = 1'b0;
    logic        toDBL = 1'b0;
    logic        toEXT = 1'b0;
    logic        toSNG = 1'b0;
    logic [2:0]  rmode = '0;
    logic [81:0] res;
    logic [1:0]  rtyp;
    logic        alt;
    logic        inexact;

    always #5 clk = ~clk;

    ifconv_round #(.BIAS(16'h7fff)) dut (
        .clk(clk), .rst(rst), .en(en), .clkEn(clkEn), .sgn(sgn), .expn(expn),
        .mant(mant), .zro(zro), .toDBL(toDBL), .toEXT(toEXT), .toSNG(toSNG),
        .rmode(rmode), .res(res), .rtyp(rtyp), .alt(alt), .inexact(inexact)
    );

    typedef struct {
        logic [81:0] res;
        logic [1:0]  rtyp;
        logic        inx;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned ecount = 0;

    task automatic check(input string name, input logic [81:0] act, input logic [81:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [81:0] r, input logic [1:0] t, input logic x);
        exp_t o;
        o.res = r; o.rtyp = t; o.inx = x; o.due = 0;
        return o;
    endfunction

    // Value-level rounding: quotient/remainder against the half-ulp point.
    function automatic exp_t model(input logic s, input logic [15:0] ex, input logic [63:0] mt,
                                   input logic z, input logic [1:0] f, input logic [2:0] rm);
        int unsigned shift;
        logic [64:0] keep, rem, half, rk, top;
        logic        up;
        logic [15:0] e;
        logic [63:0] m;
        exp_t        r;
        shift = (f == SNGL) ? 40 : (f == DBL) ? 11 : 0;
        r.rtyp = f;
        r.due  = 0;
        if (z) begin
            e = '0; m = '0; r.inx = 1'b0;
        end else begin
            keep = {1'b0, mt} >> shift;
            rem  = {1'b0, mt} - (keep << shift);
            half = (shift == 0) ? 65'd0 : (65'd1 << (shift - 1));
            r.inx = (rem != 0);
            up = 1'b0;
            if (rem != 0) begin
                case (rm)
                    3'd1:    up = 1'b0;
                    3'd2:    up = s;
                    3'd3:    up = !s;
                    3'd4:    up = (rem >= half);
                    default: up = (rem > half) || (rem == half && keep[0]);
                endcase
            end
            rk  = keep + {64'b0, up};
            e   = ex;
            top = 65'd1 << (64 - shift);
            if (rk == top) begin
                rk = rk >> 1;
                e  = ex + 16'd1;
            end
            rk = rk << shift;
            m  = rk[63:0];
        end
        case (f)
            SNGL:    r.res = {49'b0, e[6], s, e[15], e[6:0], m[62:40]};
            DBL:     r.res = {17'b0, e[9], s, e[15], e[8:0], m[62:43], 1'b0, m[42:11]};
            EXT:     r.res = {e[15], s, e[13:0], e[14], m[63:32], 1'b0, m[31:0]};
            default: r.res = '0;
        endcase
        return r;
    endfunction

    task automatic issue(input logic ce, input logic v, input logic s, input logic [15:0] ex,
                         input logic [63:0] mt, input logic z, input logic [1:0] f,
                         input logic [2:0] rm, input exp_t ex_item);
        exp_t it;
        @(negedge clk);
        clkEn = ce; en = v; sgn = s; expn = ex; mant = mt; zro = z; rmode = rm;
        toSNG = (f == SNGL); toDBL = (f == DBL); toEXT = (f == EXT);
        if (ce && v) begin
            it = ex_item;
            it.due = ecount + 2;
            sb.push_back(it);
        end
    endtask

    task automatic idle(input int n);
        exp_t dummy;
        dummy = mk('0, 2'b0, 1'b0);
        for (int i = 0; i < n; i++)
            issue(1'b1, 1'b0, 1'b0, 16'h0, 64'h0, 1'b0, SNGL, 3'd0, dummy);
    endtask

    always @(posedge clk)
        assert ($onehot0({toDBL, toEXT, toSNG})) else $error("illegal format combination");

    // Monitor: pops the scoreboard on enabled edges, checks holds on stalled edges.
    logic        mon_ce, mon_rst;
    logic [81:0] prev_res = '0;
    logic [1:0]  prev_rtyp = '0;
    logic        prev_alt = 1'b0;

    always @(posedge clk) begin
        mon_ce  = clkEn;
        mon_rst = rst;
        #1;
        if (mon_rst && rst) begin
            if (mon_ce) begin
                ecount++;
                if (sb.size() > 0 && sb[0].due == ecount) begin
                    check("alt", {81'b0, alt}, 82'd1);
                    check("res", res, sb[0].res);
                    check("rtyp", {80'b0, rtyp}, {80'b0, sb[0].rtyp});
                    check("inexact", {81'b0, inexact}, {81'b0, sb[0].inx});
                    void'(sb.pop_front());
                end else begin
                    check("alt_idle", {81'b0, alt}, 82'd0);
                end
            end else begin
                check("hold_res", res, prev_res);
                check("hold_rtyp", {80'b0, rtyp}, {80'b0, prev_rtyp});
                check("hold_alt", {81'b0, alt}, {81'b0, prev_alt});
            end
        end
        prev_res  = res;
        prev_rtyp = rtyp;
        prev_alt  = alt;
    end

    initial begin
        logic        s, v, ce, z;
        logic [1:0]  f;
        logic [2:0]  rm;
        logic [15:0] ex;
        logic [63:0] mt;

        #1 rst = 1'b0;
        #1;
        check("rst_res", res, '0);
        check("rst_rtyp", {80'b0, rtyp}, '0);
        check("rst_alt", {81'b0, alt}, '0);
        check("rst_inexact", {81'b0, inexact}, '0);
        @(negedge clk);
        rst = 1'b1;

        // 2^24+1 tie to even, then directed up/down/carry cases
        issue(1, 1, 0, 16'h8017, 64'h8000_0080_0000_0000, 0, SNGL, 3'd0,
              mk({49'b0, 1'b0, 1'b0, 1'b1, 7'h17, 23'h0}, SNGL, 1));
        issue(1, 1, 0, 16'h8017, 64'h8000_0080_0000_0000, 0, SNGL, 3'd3,
              mk({49'b0, 1'b0, 1'b0, 1'b1, 7'h17, 23'h1}, SNGL, 1));
        issue(1, 1, 1, 16'h8017, 64'h8000_0080_0000_0000, 0, SNGL, 3'd3,
              mk({49'b0, 1'b0, 1'b1, 1'b1, 7'h17, 23'h0}, SNGL, 1));
        issue(1, 1, 0, 16'h8017, 64'hFFFF_FF80_0000_0000, 0, SNGL, 3'd0,
              mk({49'b0, 1'b0, 1'b0, 1'b1, 7'h18, 23'h0}, SNGL, 1));
        issue(1, 1, 0, 16'h803e, 64'h8000_0000_0000_0001, 0, DBL, 3'd1,
              mk({17'b0, 1'b0, 1'b0, 1'b1, 9'h03e, 20'h0, 1'b0, 32'h0}, DBL, 1));
        issue(1, 1, 0, 16'h803e, 64'h8000_0000_0000_0001, 0, DBL, 3'd4,
              mk({17'b0, 1'b0, 1'b0, 1'b1, 9'h03e, 20'h0, 1'b0, 32'h0}, DBL, 1));
        issue(1, 1, 0, 16'h8005, 64'hDEAD_BEEF_1234_5678, 0, EXT, 3'd3,
              mk({1'b1, 1'b0, 14'h0005, 1'b0, 32'hDEADBEEF, 1'b0, 32'h12345678}, EXT, 0));
        // zero: only the sign survives, whatever mant/expn/rmode carry
        issue(1, 1, 1, 16'h1234, 64'h0000_00FF_FFFF_FFFF, 1, SNGL, 3'd2,
              mk({49'b0, 1'b0, 1'b1, 1'b0, 7'h0, 23'h0}, SNGL, 0));
        issue(1, 1, 1, 16'h1234, 64'h0000_00FF_FFFF_FFFF, 1, DBL, 3'd2,
              mk({17'b0, 1'b0, 1'b1, 63'b0}, DBL, 0));
        issue(1, 1, 1, 16'h1234, 64'h0000_00FF_FFFF_FFFF, 1, EXT, 3'd2,
              mk({1'b0, 1'b1, 80'b0}, EXT, 0));
        idle(3);

        // back-to-back with clkEn 1,0,1,1
        for (int i = 0; i < 4; i++) begin
            mt = {1'b1, 31'($urandom), $urandom};
            ex = 16'h7fff + 16'($urandom_range(0, 63));
            s  = 1'($urandom);
            issue((i != 1), 1, s, ex, mt, 0, DBL, 3'd0, model(s, ex, mt, 0, DBL, 3'd0));
        end
        idle(3);

        // reset mid-stream: two in flight, then asynchronous clear
        for (int i = 0; i < 2; i++) begin
            mt = {1'b1, 31'($urandom), $urandom};
            issue(1, 1, 0, 16'h8010, mt, 0, SNGL, 3'd3, model(0, 16'h8010, mt, 0, SNGL, 3'd3));
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        en  = 1'b0;
        #1;
        check("midrst_alt", {81'b0, alt}, '0);
        check("midrst_res", res, '0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(4);
        mt = 64'hC000_0000_0000_0400;
        issue(1, 1, 1, 16'h8020, mt, 0, DBL, 3'd2, model(1, 16'h8020, mt, 0, DBL, 3'd2));
        idle(3);

        // randomized traffic with forced ties and carry patterns
        for (int i = 0; i < 400; i++) begin
            ce = ($urandom_range(0, 3) != 0);
            v  = ($urandom_range(0, 3) != 0);
            z  = ($urandom_range(0, 15) == 0);
            s  = 1'($urandom);
            rm = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0:       f = SNGL;
                1:       f = DBL;
                default: f = EXT;
            endcase
            ex = 16'h7fff + 16'($urandom_range(0, 63));
            mt = {1'b1, 31'($urandom), $urandom};
            case ($urandom_range(0, 3))
                0: begin
                    if (f == SNGL) mt[38:0] = '0;
                    else           mt[9:0] = '0;
                end
                1: begin
                    if (f == SNGL) mt[63:40] = '1;
                    else           mt[63:11] = '1;
                end
                default: ;
            endcase
            issue(ce, v, s, ex, mt, z, f, rm, model(s, ex, mt, z, f, rm));
        end
        idle(4);
        check("drain", 82'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
